// File: rtl/booth_result_acc.sv
// rtl/booth_result_acc.sv - Booth multiplier result extender, accumulator and output FIFO
//
// Captures each 64-bit product on its one-cycle valid pulse, extends it to
// ACC_W bits (signed or unsigned), optionally adds it to a running sum, and
// queues the result in a DEPTH-entry FIFO drained through a valid/ready port.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   prod_in         64-bit product, qualified by prod_valid (single-cycle pulse)
//   sign            1: sign-extend prod_in, 0: zero-extend
//   acc_en          1: add to running sum, 0: pass extended product through
//   acc_clr         synchronous clear of the sum and the overflow flag
//   out_data        FIFO head entry (holds last value while empty)
//   out_valid       FIFO not empty
//   out_ready       sink accepts out_data
//   count           FIFO occupancy
//   overflow        sticky signed-overflow flag
//   drop            sticky lost-product flag (cleared by rst only)
module booth_result_acc #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 72
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              prod_in,
  input  logic                     prod_valid,
  input  logic                     sign,
  input  logic                     acc_en,
  input  logic                     acc_clr,
  output logic [ACC_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ACC_W-1:0] mem_q [DEPTH];

  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [ACC_W-1:0] head_q,  head_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic             ovf_q,   ovf_d;
  logic             drop_q,  drop_d;

  logic [ACC_W-1:0] ext, base, sum, acc_nxt;
  logic             add_ovf, full, pop, push;

  always_comb begin
    ext      = sign ? {{(ACC_W-64){prod_in[63]}}, prod_in}
                    : {{(ACC_W-64){1'b0}}, prod_in};
    // A same-cycle clear zeroes the addend base before the add.
    base     = acc_clr ? '0 : acc_q;
    sum      = base + ext;
    add_ovf  = acc_en & (base[ACC_W-1] == ext[ACC_W-1]) & (sum[ACC_W-1] != base[ACC_W-1]);
    acc_nxt  = acc_en ? sum : ext;

    full     = (count_q == CW'(DEPTH));
    pop      = valid_q & out_ready;
    // A full FIFO still accepts if the head leaves in the same cycle.
    push     = prod_valid & (~full | pop);

    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    valid_d  = (count_d != '0);

    acc_d    = acc_q;
    ovf_d    = ovf_q;
    if (push) begin
      acc_d = acc_nxt;
      ovf_d = (ovf_q & ~acc_clr) | add_ovf;
    end else if (acc_clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end

    drop_d   = drop_q | (prod_valid & ~push);

    // Registered head: the new entry when it lands in an otherwise empty
    // queue, the next stored entry otherwise, and a hold once drained.
    head_d   = head_q;
    if (push && (count_q == CW'(pop))) begin
      head_d = acc_nxt;
    end else if (count_d != '0) begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      head_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      head_q   <= head_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: entries are only visible after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= acc_nxt;
    end
  end

  assign out_data  = head_q;
  assign out_valid = valid_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign drop      = drop_q;

endmodule
